// File: rtl/multicycle_sequencer_if.sv
// Memory request handshakes between the multicycle sequencer
// and the instruction/data memories.
interface multicycle_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the single-issue RV32I core.
// Define SEQ_PERF_CNT_EN to build the cycle/instret counters.
module multicycle_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    multicycle_sequencer_if.master mem,
    output logic        ir_we,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        bad_opcode,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       retire;

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        trap         = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                halted = 1'b1;
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem.imem_req = 1'b1;
                ir_we        = mem.imem_ready;
                if (mem.imem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bad_opcode) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken;
                    retire = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = is_store;
                if (mem.dmem_ready) begin
                    // a load still needs its writeback cycle
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                pc_sel = is_jump;
                retire = 1'b1;
                if (is_load) begin
                    wb_sel = 2'd1;
                end else if (is_jump) begin
                    wb_sel = 2'd2;
                end else begin
                    wb_sel = 2'd0;
                end
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire) begin
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] instret_cnt_q;
    logic [31:0] instret_cnt_d;
    logic        active;

    always_comb begin
        active        = (state_q != S_IDLE) && (state_q != S_TRAP);
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (active) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (pc_we) begin
            instret_cnt_d = instret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control FSM for the single-issue RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. The decoder's classification flags (load, store, branch, jump, bad opcode) steer it, and it drives the PC, IR, register-file and data-memory enables. It owns the instruction- and data-memory request handshakes, and it owns the trap and halt status of the core.

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  permit sequencing; sampled in IDLE and at each retire
- imem_ready  in  1  instruction word valid this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- is_load, is_store, is_branch, is_jump, bad_opcode  in  1 each  decoder flags, decoded from the latched IR, valid from DECODE onward
- branch_taken  in  1  branch comparator result, valid in EXEC
- dmem_ready  in  1  data access complete this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write enable, qualified by dmem_req
- pc_we  out  1  update PC (also marks retire)
- pc_sel  out  1  PC source: 0 = pc+4, 1 = ALU result
- reg_we  out  1  register-file write
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = pc+4
- trap  out  1  illegal instruction seen; sticky
- halted  out  1  FSM in IDLE
- cycle_cnt  out  32  active-cycle counter
- instret_cnt  out  32  retired-instruction counter

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are combinational from the state and the current inputs.

- **IDLE**
  - Outputs: halted=1.
  - Transition: run=1 -> FETCH.
- **FETCH**
  - Outputs: imem_req=1, held until imem_ready. ir_we=imem_ready, in the same cycle.
  - Transition: on imem_ready -> DECODE.
  - run is ignored here; an open request is never withdrawn.
- **DECODE**
  - Duration: 1 cycle.
  - Transition: bad_opcode -> TRAP; otherwise -> EXEC.
- **EXEC**
  - Duration: 1 cycle.
  - Transitions:
    - is_load or is_store -> MEM.
    - is_branch: pc_we=1, pc_sel=branch_taken -> retire.
    - Otherwise, including jumps -> WB.
- **MEM**
  - Outputs: dmem_req=1 and dmem_we=is_store, both held stable until dmem_ready.
  - Transition on dmem_ready:
    - store: pc_we=1, pc_sel=0 -> retire.
    - load -> WB.
- **WB**
  - Outputs: reg_we=1, pc_we=1, pc_sel=is_jump.
  - wb_sel: 1 if is_load, 2 if is_jump, otherwise 0.
  - Transition: -> retire.
- **Retire**
  - Defined as the pc_we=1 cycle.
  - Next state is FETCH if run=1, otherwise IDLE.
- **TRAP**
  - Terminal state; trap=1.
  - All enables and requests are 0; run is ignored.
  - Exit only via rst_n.
- **Flag precedence:** bad_opcode > load/store > branch > jump. The decoder guarantees the flags are one-hot, but the FSM follows this order regardless.

## Timing
- **Reset (rst_n low, asynchronous):**
  - State = IDLE.
  - halted=1.
  - All other outputs 0.
  - Counters = 0.
- **Minimum latency, with imem_ready and dmem_ready tied to 1:**
  - ALU op or jump: 4 cycles (F, D, E, W).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- **Back-to-back instructions:** FETCH of the next instruction is entered on the cycle after retire, so there is no bubble.
- **Memory wait states:** each cycle of ready=0 adds one cycle in FETCH or MEM. The request and dmem_we stay constant while waiting.
- **run deassertion:**
  - Mid-instruction: the instruction completes, then the FSM enters IDLE.
  - In IDLE: the FSM stays put.
- **Reset mid-operation:** an asynchronous abort with no completion. Any open memory request drops immediately.

## Configuration
- **SEQ_PERF_CNT_EN defined:**
  - cycle_cnt increments in every cycle whose state is not IDLE or TRAP.
  - instret_cnt increments on every pc_we=1 cycle.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- **SEQ_PERF_CNT_EN undefined:**
  - Both ports remain present, tied to 0.
  - No counter flops are synthesized.

## Test plan
- Reset, run=1, both readies=1, ADD (no flags set):
  - Sequence FETCH, DECODE, EXEC, WB.
  - The WB cycle shows reg_we=1, wb_sel=0, pc_we=1, pc_sel=0.
  - FETCH re-entered on the next cycle.
- LW with dmem_ready low for 3 cycles:
  - dmem_req=1 for 4 cycles with dmem_we=0.
  - Then WB with wb_sel=1 and reg_we=1.
  - 8 cycles total.
- BEQ with branch_taken=1:
  - EXEC cycle shows pc_we=1, pc_sel=1, reg_we=0; 3 cycles total.
  - Repeat with branch_taken=0: pc_sel=0.
- bad_opcode=1:
  - trap=1 from the cycle after DECODE.
  - No pc_we, reg_we or dmem_req.
  - trap stays 1 across run toggling.
  - Pulse rst_n: trap=0, halted=1.
- run dropped during FETCH with imem_ready=0 for 2 cycles:
  - imem_req stays 1 until ready.
  - The ADD retires.
  - Then halted=1 and imem_req=0.
- With SEQ_PERF_CNT_EN, 10 back-to-back ADDs, run dropped during the last:
  - At halt: instret_cnt=10, cycle_cnt=40.
  - Without the macro, both read 0.
